seg7_scan_encoder: RTL and testbench

Receive-side counterpart to the segment decoders: watches a multiplexed common-cathode 7-segment display bus (segment lines plus one-hot digit enables), debounces each digit dwell, maps each segment pattern back to a 4-bit hex value, and assembles a complete DIGITS-digit frame. It sits between the display-driving logic and any checker or host logic that needs the displayed number as data. It presents that number on a valid/ready output with one frame of buffering.

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_scan_encoder_if.sv | 14 +
 rtl/seg7_pattern_to_hex.sv | 35 +++
 rtl/seg7_scan_encoder.sv | 127 ++++++++++++
 tb/tb_seg7_scan_encoder.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: abcdefg patterns (bit 6 = a, active-high)
// and the frame assembler state encoding.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h1F;
  localparam logic [6:0] SEG_C     = 7'h4E;
  localparam logic [6:0] SEG_D     = 7'h3D;
  localparam logic [6:0] SEG_E     = 7'h4F;
  localparam logic [6:0] SEG_F     = 7'h47;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    ST_COLLECT  = 1'b0,
    ST_COMPLETE = 1'b1
  } asm_state_e;

endpackage

// File: rtl/seg7_scan_encoder_if.sv
// Frame output stream of the scan encoder: assembled value plus error flag
// on valid/ready, with the overflow pulse alongside.
interface seg7_scan_encoder_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic                err;
  logic                valid;
  logic                ready;
  logic                overflow;

  modport master (output value, output err, output valid, output overflow, input ready);
  modport slave  (input value, input err, input valid, input overflow, output ready);
endinterface

// File: rtl/seg7_pattern_to_hex.sv
// Combinational reverse decoder: maps a 7-segment pattern back to its hex
// nibble, flagging anything that is not one of the 16 glyphs.
module seg7_pattern_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       invalid
);

  always_comb begin
    nibble  = 4'h0;
    invalid = 1'b0;
    case (pattern)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_encoder.sv
// Watches a multiplexed 7-segment bus, debounces each digit dwell, decodes it
// and hands complete frames out through a one-deep valid/ready buffer.
module seg7_scan_encoder
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           seg_i,
  input  logic [DIGITS-1:0]    dig_en_i,
  seg7_scan_encoder_if.master  frame
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  logic [6:0]          samp_seg;
  logic [DIGITS-1:0]   samp_en;
  logic [7:0]          count, count_next;
  logic                dwell, dwell_next;
  logic                same, en_onehot, capture;
  logic [3:0]          nibble;
  logic                invalid;

  asm_state_e          state, state_next;
  logic [4*DIGITS-1:0] slots, slots_next;
  logic [DIGITS-1:0]   captured, captured_next;
  logic [DIGITS-1:0]   slot_err, slot_err_next;
  logic [4*DIGITS-1:0] value_next;
  logic                err_next, valid_next, overflow_next;

  seg7_pattern_to_hex u_decode (
    .pattern (samp_seg),
    .nibble  (nibble),
    .invalid (invalid)
  );

  assign same      = (seg_i == samp_seg) && (dig_en_i == samp_en);
  assign en_onehot = (dig_en_i != '0) && ((dig_en_i & (dig_en_i - DIGITS'(1))) == '0);
  // Count reaches its ceiling only for a one-hot sample, so capture can trust samp_en.
  assign capture   = (count == STABLE_MAX) && !dwell;

  always_comb begin
    count_next = en_onehot ? 8'd1 : 8'd0;
    if (same && en_onehot)
      count_next = (count == STABLE_MAX) ? count : count + 8'd1;
    dwell_next = !same ? 1'b0 : (capture ? 1'b1 : dwell);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_seg <= '0;
      samp_en  <= '0;
      count    <= '0;
      dwell    <= 1'b0;
    end else begin
      samp_seg <= seg_i;
      samp_en  <= dig_en_i;
      count    <= count_next;
      dwell    <= dwell_next;
    end
  end

  // COMPLETE is entered on the same edge as the last capture, so the handoff
  // happens one edge later and the slots are free again for the next scan.
  always_comb begin
    slots_next    = slots;
    captured_next = captured;
    slot_err_next = slot_err;
    value_next    = frame.value;
    err_next      = frame.err;
    valid_next    = frame.valid;
    overflow_next = 1'b0;

    if (frame.valid && frame.ready)
      valid_next = 1'b0;

    if (state == ST_COMPLETE) begin
      if (!frame.valid || frame.ready) begin
        value_next = slots;
        err_next   = |slot_err;
        valid_next = 1'b1;
      end else begin
        overflow_next = 1'b1;
      end
      slots_next    = '0;
      captured_next = '0;
      slot_err_next = '0;
    end

    if (capture) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (samp_en[i]) begin
          slots_next[4*i +: 4] = nibble;
          captured_next[i]     = 1'b1;
          slot_err_next[i]     = invalid;
        end
      end
    end

    state_next = (&captured_next) ? ST_COMPLETE : ST_COLLECT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_COLLECT;
      slots          <= '0;
      captured       <= '0;
      slot_err       <= '0;
      frame.value    <= '0;
      frame.err      <= 1'b0;
      frame.valid    <= 1'b0;
      frame.overflow <= 1'b0;
    end else begin
      state          <= state_next;
      slots          <= slots_next;
      captured       <= captured_next;
      slot_err       <= slot_err_next;
      frame.value    <= value_next;
      frame.err      <= err_next;
      frame.valid    <= valid_next;
      frame.overflow <= overflow_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_encoder.sv
// Directed bench for seg7_scan_encoder (DIGITS=4, STABLE_CYCLES=4) with
// hand-computed frames; a negedge monitor logs accepted frames and overflows.
module tb_seg7_scan_encoder;
  import seg7_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg_i;
  logic [3:0] dig_en_i;

  int checks;
  int errors;
  int frame_cnt;
  int ovf_cnt;
  logic [15:0] last_value;
  logic        last_err;

  seg7_scan_encoder_if #(.DIGITS(4)) frame_if ();

  seg7_scan_encoder #(
    .DIGITS        (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .seg_i    (seg_i),
    .dig_en_i (dig_en_i),
    .frame    (frame_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every frame accepted by the consumer and every overflow pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_if.valid && frame_if.ready) begin
        frame_cnt++;
        last_value = frame_if.value;
        last_err   = frame_if.err;
      end
      if (frame_if.overflow)
        ovf_cnt++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Called just after a rising edge; holds the inputs for n edges.
  task automatic applyStimulus(input logic [6:0] seg, input logic [3:0] en, input int n);
    seg_i    = seg;
    dig_en_i = en;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scanFrame(input logic [6:0] p0, input logic [6:0] p1,
                           input logic [6:0] p2, input logic [6:0] p3);
    applyStimulus(p0, 4'b0001, 6);
    applyStimulus(p1, 4'b0010, 6);
    applyStimulus(p2, 4'b0100, 6);
    applyStimulus(p3, 4'b1000, 6);
  endtask

  initial begin
    int base_frames;
    int base_ovf;
    checks     = 0;
    errors     = 0;
    frame_cnt  = 0;
    ovf_cnt    = 0;
    last_value = '0;
    last_err   = 1'b0;
    rst_n      = 1'b0;
    seg_i      = SEG_BLANK;
    dig_en_i   = 4'b0000;
    frame_if.ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(SEG_BLANK, 4'b0000, 3);
    checkOutput("reset_value", 32'(frame_if.value), 32'h0);
    checkOutput("reset_err", 32'(frame_if.err), 32'h0);
    checkOutput("reset_valid", 32'(frame_if.valid), 32'h0);
    checkOutput("reset_overflow", 32'(frame_if.overflow), 32'h0);

    // Basic scan 1,2,3,4; valid must rise on the 6th edge of the last digit.
    scanFrame(SEG_1, SEG_2, SEG_3, SEG_4);
    checkOutput("t1_valid_rise", 32'(frame_if.valid), 32'h1);
    checkOutput("t1_value", 32'(frame_if.value), 32'h4321);
    checkOutput("t1_err", 32'(frame_if.err), 32'h0);
    applyStimulus(SEG_BLANK, 4'b0000, 1);
    checkOutput("t1_valid_drop", 32'(frame_if.valid), 32'h0);
    checkOutput("t1_frame_count", 32'(frame_cnt), 32'd1);
    applyStimulus(SEG_BLANK, 4'b0000, 2);

    // Short last-digit dwell and a multi-hot enable must never complete a frame.
    base_frames = frame_cnt;
    applyStimulus(SEG_9, 4'b0001, 6);
    applyStimulus(SEG_9, 4'b0010, 6);
    applyStimulus(SEG_9, 4'b0100, 6);
    applyStimulus(SEG_9, 4'b1000, 3);
    applyStimulus(SEG_BLANK, 4'b0000, 10);
    checkOutput("t2_short_dwell", 32'(frame_cnt - base_frames), 32'd0);
    applyStimulus(SEG_9, 4'b1100, 10);
    applyStimulus(SEG_BLANK, 4'b0000, 4);
    checkOutput("t2_multi_hot", 32'(frame_cnt - base_frames), 32'd0);
    checkOutput("t2_no_valid", 32'(frame_if.valid), 32'h0);
    scanFrame(SEG_5, SEG_6, SEG_7, SEG_8);
    checkOutput("t2_clean_value", 32'(frame_if.value), 32'h8765);
    applyStimulus(SEG_BLANK, 4'b0000, 2);
    checkOutput("t2_frame_count", 32'(frame_cnt - base_frames), 32'd1);
    checkOutput("t2_last_err", 32'(last_err), 32'h0);

    // Unrecognised patterns decode to 0 and raise err.
    scanFrame(7'h01, SEG_7, SEG_BLANK, SEG_F);
    checkOutput("t3_value", 32'(frame_if.value), 32'hF070);
    checkOutput("t3_err", 32'(frame_if.err), 32'h1);
    applyStimulus(SEG_BLANK, 4'b0000, 2);

    // Consumer stalls across two scans: second frame is dropped.
    frame_if.ready = 1'b0;
    base_ovf = ovf_cnt;
    scanFrame(SEG_D, SEG_C, SEG_B, SEG_A);
    checkOutput("t4_first_value", 32'(frame_if.value), 32'hABCD);
    scanFrame(SEG_0, SEG_0, SEG_0, SEG_0);
    checkOutput("t4_overflow_pulse", 32'(frame_if.overflow), 32'h1);
    checkOutput("t4_value_held", 32'(frame_if.value), 32'hABCD);
    applyStimulus(SEG_BLANK, 4'b0000, 1);
    checkOutput("t4_overflow_clear", 32'(frame_if.overflow), 32'h0);
    checkOutput("t4_valid_held", 32'(frame_if.valid), 32'h1);
    checkOutput("t4_overflow_count", 32'(ovf_cnt - base_ovf), 32'd1);
    frame_if.ready = 1'b1;
    applyStimulus(SEG_BLANK, 4'b0000, 1);
    checkOutput("t4_valid_drop", 32'(frame_if.valid), 32'h0);
    checkOutput("t4_accepted", 32'(last_value), 32'hABCD);
    applyStimulus(SEG_BLANK, 4'b0000, 2);

    // Ready accepts the held frame on the very edge the next frame loads.
    frame_if.ready = 1'b0;
    base_ovf = ovf_cnt;
    scanFrame(SEG_7, SEG_5, SEG_3, SEG_1);
    checkOutput("t5_first_value", 32'(frame_if.value), 32'h1357);
    applyStimulus(SEG_2, 4'b0001, 6);
    applyStimulus(SEG_4, 4'b0010, 6);
    applyStimulus(SEG_6, 4'b0100, 6);
    applyStimulus(SEG_8, 4'b1000, 5);
    frame_if.ready = 1'b1;
    applyStimulus(SEG_8, 4'b1000, 1);
    checkOutput("t5_valid_kept", 32'(frame_if.valid), 32'h1);
    checkOutput("t5_new_value", 32'(frame_if.value), 32'h8642);
    checkOutput("t5_old_accepted", 32'(last_value), 32'h1357);
    checkOutput("t5_no_overflow", 32'(ovf_cnt - base_ovf), 32'd0);
    applyStimulus(SEG_BLANK, 4'b0000, 1);
    checkOutput("t5_second_accepted", 32'(last_value), 32'h8642);
    checkOutput("t5_valid_drop", 32'(frame_if.valid), 32'h0);
    applyStimulus(SEG_BLANK, 4'b0000, 2);

    // Reset mid-scan with a frame held: outputs clear at once, partial frame lost.
    frame_if.ready = 1'b0;
    scanFrame(SEG_5, SEG_5, SEG_5, SEG_5);
    checkOutput("t6_held_value", 32'(frame_if.value), 32'h5555);
    applyStimulus(SEG_9, 4'b0001, 6);
    applyStimulus(SEG_9, 4'b0010, 6);
    applyStimulus(SEG_9, 4'b0100, 2);
    rst_n = 1'b0;
    #2;
    checkOutput("t6_reset_value", 32'(frame_if.value), 32'h0);
    checkOutput("t6_reset_valid", 32'(frame_if.valid), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    frame_if.ready = 1'b1;
    base_frames = frame_cnt;
    applyStimulus(SEG_E, 4'b0100, 6);
    applyStimulus(SEG_E, 4'b1000, 6);
    applyStimulus(SEG_BLANK, 4'b0000, 4);
    checkOutput("t6_partial_discarded", 32'(frame_cnt - base_frames), 32'd0);
    applyStimulus(SEG_C, 4'b0001, 6);
    applyStimulus(SEG_C, 4'b0010, 6);
    checkOutput("t6_post_reset_value", 32'(frame_if.value), 32'hEECC);
    applyStimulus(SEG_BLANK, 4'b0000, 2);
    checkOutput("t6_frame_count", 32'(frame_cnt - base_frames), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
